// File: rtl/phase_sequencer.sv
// N-phase one-hot phase generator: halt (immediate or cycle-boundary), single-cycle step, wait-state stretch.
// All outputs registered; a stretched edge holds every register and adds one edge to the current phase.
module phase_sequencer #(
   parameter int PHASES    = 3,
   parameter int HALT_MODE = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              step,
   input  logic              wait_req,
   output logic [PHASES-1:0] phase_out,
   output logic              running,
   output logic              halted,
   output logic              cycle_done,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int PTR_W = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(PHASES - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALTED,
      ST_STEP
   } state_t;

   state_t           r_state;
   logic [PTR_W-1:0] r_ptr;

   logic              w_last;
   logic              w_stretch;
   logic              w_halt_cond;
   logic [PTR_W-1:0]  w_ptr_adv;
   logic [PHASES-1:0] w_onehot;

   assign w_last      = (r_ptr == '0);
   assign w_ptr_adv   = w_last ? PTR_FIRST : r_ptr - 1'b1;
   assign w_onehot    = {{(PHASES-1){1'b0}}, 1'b1} << r_ptr;
   assign w_stretch   = wait_req && (phase_out != '0) && (r_state != ST_HALTED);
   // Boundary mode only stops once the previous cycle has fully completed.
   assign w_halt_cond = halt && ((HALT_MODE == 0) || (r_ptr == PTR_FIRST));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_ptr       <= PTR_FIRST;
         phase_out   <= '0;
         cycle_done  <= 1'b0;
         cycle_count <= '0;
         running     <= 1'b1;
         halted      <= 1'b0;
      end else begin
         cycle_done <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (!w_stretch) begin
                  if (w_halt_cond) begin
                     phase_out <= '0;
                     r_state   <= ST_HALTED;
                     running   <= 1'b0;
                     halted    <= 1'b1;
                  end else begin
                     phase_out  <= w_onehot;
                     r_ptr      <= w_ptr_adv;
                     cycle_done <= w_last;
                     if (w_last) cycle_count <= cycle_count + 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               if (!halt || step) begin
                  phase_out  <= w_onehot;
                  r_ptr      <= w_ptr_adv;
                  cycle_done <= w_last;
                  if (w_last) cycle_count <= cycle_count + 1'b1;
                  r_state    <= halt ? ST_STEP : ST_RUN;
                  running    <= 1'b1;
                  halted     <= 1'b0;
               end
            end
            ST_STEP: begin
               // The bit-0 phase just emitted means the stepped cycle is finished.
               if (!w_stretch) begin
                  if (phase_out[0]) begin
                     phase_out <= '0;
                     r_state   <= ST_HALTED;
                     running   <= 1'b0;
                     halted    <= 1'b1;
                  end else begin
                     phase_out  <= w_onehot;
                     r_ptr      <= w_ptr_adv;
                     cycle_done <= w_last;
                     if (w_last) cycle_count <= cycle_count + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_RUN;
               running <= 1'b1;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Three sequencer configurations driven in lockstep, each compared every edge against a reference model.
module tb_phase_sequencer;

   localparam int NI     = 3;
   localparam int M_RUN  = 0;
   localparam int M_HLT  = 1;
   localparam int M_STEP = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic halt = 1'b0;
   logic step = 1'b0;
   logic wait_req = 1'b0;

   always #5 clk = ~clk;

   logic [2:0]  pa, pb;
   logic [4:0]  pc;
   logic        run_a, run_b, run_c, hlt_a, hlt_b, hlt_c, cd_a, cd_b, cd_c;
   logic [1:0]  cnt_a;
   logic [15:0] cnt_b;
   logic [3:0]  cnt_c;

   phase_sequencer #(.PHASES(3), .HALT_MODE(1), .CNT_W(2)) dut_a (
      .clk(clk), .reset(reset), .halt(halt), .step(step), .wait_req(wait_req),
      .phase_out(pa), .running(run_a), .halted(hlt_a), .cycle_done(cd_a), .cycle_count(cnt_a));
   phase_sequencer #(.PHASES(3), .HALT_MODE(0), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .halt(halt), .step(step), .wait_req(wait_req),
      .phase_out(pb), .running(run_b), .halted(hlt_b), .cycle_done(cd_b), .cycle_count(cnt_b));
   phase_sequencer #(.PHASES(5), .HALT_MODE(0), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .halt(halt), .step(step), .wait_req(wait_req),
      .phase_out(pc), .running(run_c), .halted(hlt_c), .cycle_done(cd_c), .cycle_count(cnt_c));

   logic [31:0] po [NI];
   logic [31:0] cc [NI];
   logic [31:0] rn [NI];
   logic [31:0] hl [NI];
   logic [31:0] cd [NI];

   assign po[0] = 32'(pa);    assign po[1] = 32'(pb);    assign po[2] = 32'(pc);
   assign cc[0] = 32'(cnt_a); assign cc[1] = 32'(cnt_b); assign cc[2] = 32'(cnt_c);
   assign rn[0] = 32'(run_a); assign rn[1] = 32'(run_b); assign rn[2] = 32'(run_c);
   assign hl[0] = 32'(hlt_a); assign hl[1] = 32'(hlt_b); assign hl[2] = 32'(hlt_c);
   assign cd[0] = 32'(cd_a);  assign cd[1] = 32'(cd_b);  assign cd[2] = 32'(cd_c);

   int m_p  [NI] = '{3, 3, 5};
   int m_hm [NI] = '{1, 0, 0};
   int m_cw [NI] = '{2, 16, 4};
   int m_st [NI];
   int m_ptr [NI];
   int m_out [NI];
   int m_left [NI];
   int m_cd [NI];
   int m_cnt [NI];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s[%0d] got=%0h expected=%0h", tag, k, got, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_st[k]   = M_RUN;
      m_ptr[k]  = m_p[k] - 1;
      m_out[k]  = -1;
      m_left[k] = 0;
      m_cd[k]   = 0;
      m_cnt[k]  = 0;
   endtask

   task automatic model_emit(input int k);
      m_out[k] = m_ptr[k];
      m_cd[k]  = (m_ptr[k] == 0) ? 1 : 0;
      if (m_cd[k] == 1) m_cnt[k] = (m_cnt[k] + 1) % (1 << m_cw[k]);
      m_ptr[k] = (m_ptr[k] == 0) ? m_p[k] - 1 : m_ptr[k] - 1;
   endtask

   task automatic model_edge(input int k);
      m_cd[k] = 0;
      if (wait_req && m_out[k] >= 0 && m_st[k] != M_HLT) return;
      case (m_st[k])
         M_RUN: begin
            if (halt && (m_hm[k] == 0 || m_ptr[k] == m_p[k] - 1)) begin
               m_out[k] = -1;
               m_st[k]  = M_HLT;
            end else model_emit(k);
         end
         M_HLT: begin
            if (!halt) begin
               model_emit(k);
               m_st[k] = M_RUN;
            end else if (step) begin
               m_left[k] = m_ptr[k] + 1;
               model_emit(k);
               m_left[k]--;
               m_st[k] = M_STEP;
            end
         end
         default: begin
            if (m_left[k] == 0) begin
               m_out[k] = -1;
               m_st[k]  = M_HLT;
            end else begin
               model_emit(k);
               m_left[k]--;
            end
         end
      endcase
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk("phase_out", k, po[k], (m_out[k] < 0) ? 32'd0 : (32'd1 << m_out[k]));
         chk("cycle_done", k, cd[k], 32'(m_cd[k]));
         chk("running", k, rn[k], 32'(m_st[k] != M_HLT));
         chk("halted", k, hl[k], 32'(m_st[k] == M_HLT));
         chk("cycle_count", k, cc[k], 32'(m_cnt[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < NI; k++) model_edge(k);
      @(negedge clk);
      check_all();
   endtask

   // Reset asserted between edges must clear outputs without waiting for a clock.
   task automatic async_reset();
      #2 reset = 1'b1;
      for (int k = 0; k < NI; k++) model_reset(k);
      #1 check_all();
      chk("arst_po", 0, po[0], 32'd0);
      chk("arst_cnt", 0, cc[0], 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   int exp3 [3] = '{4, 2, 1};
   int exp4 [4] = '{4, 2, 1, 0};
   logic [31:0] save_cnt;

   initial begin
      for (int k = 0; k < NI; k++) model_reset(k);
      #1 reset = 1'b1;
      #3 check_all();
      chk("rst_po", 0, po[0], 32'd0);
      chk("rst_run", 0, rn[0], 32'd1);
      chk("rst_hlt", 0, hl[0], 32'd0);
      chk("rst_cnt", 0, cc[0], 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         tick();
         chk("seq_po", 0, po[0], 32'(exp3[i % 3]));
         chk("seq_cd", 0, cd[0], 32'(i % 3 == 2));
         if (i % 3 == 2) chk("seq_cnt", 0, cc[0], 32'(i / 3 + 1));
      end

      tick(); tick();
      chk("pre_halt", 0, po[0], 32'd2);
      halt = 1'b1;
      tick();
      chk("hm1_last", 0, po[0], 32'd1);
      chk("hm1_cd", 0, cd[0], 32'd1);
      chk("hm1_wrap", 0, cc[0], 32'd0);
      chk("hm0_stop", 1, po[1], 32'd0);
      chk("hm0_hlt", 1, hl[1], 32'd1);
      tick();
      chk("hm1_stop", 0, po[0], 32'd0);
      chk("hm1_hlt", 0, hl[0], 32'd1);
      tick();
      halt = 1'b0;
      tick();
      chk("hm1_resume", 0, po[0], 32'd4);
      chk("hm0_resume", 1, po[1], 32'd1);
      chk("hm0_cd", 1, cd[1], 32'd1);
      tick();
      chk("hm0_next", 1, po[1], 32'd4);

      halt = 1'b1;
      tick(); tick();
      chk("pre_step_hlt", 0, hl[0], 32'd1);
      chk("pre_step_cnt", 0, cc[0], 32'd1);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_p0", 0, po[0], 32'd4);
      tick(); chk("step_p1", 0, po[0], 32'd2);
      tick(); chk("step_p2", 0, po[0], 32'd1);
      chk("step_cnt", 0, cc[0], 32'd2);
      tick(); chk("step_end", 0, po[0], 32'd0);
      chk("step_hlt", 0, hl[0], 32'd1);

      step = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("step_hold", 0, po[0], 32'(exp4[i % 4]));
      end
      step = 1'b0;
      tick(); tick();
      chk("step_hold_end", 0, hl[0], 32'd1);

      halt = 1'b0;
      tick(); tick();
      save_cnt = cc[0];
      wait_req = 1'b1;
      tick(); chk("wait_h1", 0, po[0], 32'd2);
      tick(); chk("wait_h2", 0, po[0], 32'd2);
      chk("wait_cnt", 0, cc[0], save_cnt);
      wait_req = 1'b0;
      tick(); chk("wait_rel", 0, po[0], 32'd1);
      chk("wait_cnt_inc", 0, cc[0], (save_cnt + 32'd1) % 32'd4);

      halt = 1'b1;
      tick(); chk("wstep_hlt", 0, hl[0], 32'd1);
      step = 1'b1;
      tick(); chk("wstep_p0", 0, po[0], 32'd4);
      step = 1'b0;
      tick(); chk("wstep_p1", 0, po[0], 32'd2);
      wait_req = 1'b1;
      tick(); chk("wstep_h1", 0, po[0], 32'd2);
      tick(); chk("wstep_h2", 0, po[0], 32'd2);
      wait_req = 1'b0;
      tick(); chk("wstep_p2", 0, po[0], 32'd1);
      tick(); chk("wstep_end", 0, po[0], 32'd0);

      halt = 1'b0;
      async_reset();
      for (int i = 0; i < 16; i++) tick();
      chk("pre_arst_cnt", 0, cc[0], 32'd1);
      chk("pre_arst_po", 0, po[0], 32'd4);
      async_reset();
      tick();
      chk("post_arst_po", 0, po[0], 32'd4);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(5) == 0) halt = ~halt;
         step     = ($urandom_range(2) == 0);
         wait_req = ($urandom_range(4) == 0);
         tick();
         if ($urandom_range(249) == 0) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised N-phase, one-hot phase generator that sequences the core's per-instruction clock phases (cycle, RAM, internal, …) from the single system clock. It extends the fixed three-phase generator in four ways: a configurable phase count, an immediate or cycle-boundary halt mode, single-cycle stepping while halted, and wait-state stretching of the current phase. It also provides a completed-cycle counter for debug and performance monitoring. It sits between the top-level clock/control inputs and every phase-clocked unit.

## Interface
- PHASES, 3: number of phases per cycle; legal range 2..16.
- HALT_MODE, 1: 0 = halt takes effect at the next edge (mid-cycle); 1 = halt takes effect only at a cycle boundary.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- halt  in  1  level; requests stopping the phase sequence.
- step  in  1  level, sampled only in HALTED; starts exactly one cycle run.
- wait_req  in  1  level; stretches the phase currently being driven.
- phase_out  out  PHASES  registered one-hot phase vector; bit PHASES-1 is the first phase of a cycle, bit 0 the last.
- running  out  1  high in RUN or STEP.
- halted  out  1  high in HALTED.
- cycle_done  out  1  one-clock pulse, coincident with the phase_out bit 0 emission.
- cycle_count  out  CNT_W  number of completed cycles, modulo 2^CNT_W.

## Operation
- Internal pointer ptr ($clog2(PHASES) bits) holds the index of the next phase to emit. Advancing moves it PHASES-1 → … → 0 → PHASES-1.
- States: RUN, HALTED, STEP. The reset state is RUN.
- Emit: phase_out <= 1<<ptr, then advance ptr. If ptr was 0, also cycle_done <= 1 and cycle_count increments (wraps to 0).
- Stretch rule, applies in RUN and STEP: if wait_req=1 and phase_out≠0, all registers hold, including phase_out. cycle_done is 0 on held edges. Stretch has priority over halt.
- Halt condition:
  - HALT_MODE=0: halt=1.
  - HALT_MODE=1: halt=1 and ptr=PHASES-1, i.e. no partial cycle is outstanding.
- RUN, per edge, not stretched:
  - If the halt condition holds: phase_out <= 0, go to HALTED. ptr is kept.
  - Otherwise: emit.
- HALTED: phase_out=0, cycle_done=0.
  - halt=0: emit at that same edge and go to RUN.
  - halt=1 and step=1: emit and go to STEP.
  - Otherwise: stay in HALTED.
- STEP: emit each edge until an emission with ptr=0 has been made. At the next non-stretched edge, phase_out <= 0 and go to HALTED.
  - halt and step are ignored in STEP.
  - With HALT_MODE=0 and a mid-cycle halt, STEP completes the partial cycle only.
- step held high: one cycle per HALTED entry. A new step run starts at the first HALTED edge where step=1.

## Timing
- All outputs are registered. Reset values: phase_out=0, cycle_done=0, cycle_count=0, running=1, halted=0, ptr=PHASES-1, state=RUN.
- Reset asserted mid-operation clears every output immediately, with no clock edge, and cycle_count returns to 0.
- First edge after reset release with halt=0: phase_out=1<<(PHASES-1).
- Nominal cycle length: PHASES edges. Each stretched edge adds 1.
- Halt latency:
  - HALT_MODE=0: phase_out=0 one edge after halt is sampled.
  - HALT_MODE=1: phase_out=0 on the edge after the bit-0 phase is emitted.
- Resume latency: the first phase appears on the edge at which halt=0 is sampled in HALTED.
- running and halted update on the same edge as the state change.

## Test plan
- PHASES=3, halt=0 after reset → phase_out 100,010,001,100,…; cycle_done high with every 001; cycle_count 1,2,3 after 3,6,9 edges.
- HALT_MODE=1, halt raised while phase_out=010 → 001 (cycle_done=1) then 000 with halted=1. halt lowered → 100 on that edge.
- HALT_MODE=0, halt raised while phase_out=010 → next edge 000. After release → 001, cycle_done=1, then 100.
- HALTED, step pulsed for one edge → 100,010,001,000; cycle_count +1; halted returns to 1. step held for 10 edges → two full cycles separated by one 000 edge.
- wait_req=1 for two edges while phase_out=010 → 010 held for three edges total, then 001; cycle_count unaffected until 001. Same applied during STEP → same hold.
- Reset asserted asynchronously mid-cycle with CNT_W=2 after 5 cycles (count=1, already wrapped) → phase_out=0 and cycle_count=0 before the next clock edge. Release → 100.
